fifo_stream_adapter: RTL and testbench
======================================

FIFO_STREAM_ADAPTER -- requirements
Module: fifo_stream_adapter

Interface
REQ-001 The block SHALL have the parameter WIDTH, default 8, which sets the data width in bits.
REQ-002 The block SHALL have the parameter REGOUT, default 1, which sets the upstream FIFO read latency: 1 means a registered read, 0 means a combinational read.
REQ-003 The block SHALL have one clock and an asynchronous active-high reset, with ports as follows:
- clk  input  1  clock.
- rst  input  1  asynchronous active-high reset.
- clr  input  1  synchronous flush.
REQ-004 The block SHALL have these ports on the FIFO read side:
- fifo_rd_en  output  1  read strobe.
- fifo_rd_data  input  WIDTH  FIFO read data.
- fifo_empty  input  1  FIFO empty flag.
- fifo_clr  output  1  FIFO flush.
REQ-005 The block SHALL have these ports on the stream side:
- m_valid  output  1  output data valid.
- m_ready  input  1  downstream accept.
- m_data  output  WIDTH  output data.

Function
REQ-006 The block SHALL convert the FIFO rd_en/empty read port into a valid/ready stream through an internal 2-entry skid buffer, with occupancy occ in 0..2.
REQ-007 When REGOUT=1, an in-flight flag SHALL be set in the cycle after a cycle with fifo_rd_en=1.
- That in-flight word SHALL be captured from fifo_rd_data at the end of that following cycle.
REQ-008 When REGOUT=0, fifo_rd_data SHALL be captured at the end of the same cycle in which fifo_rd_en=1.
REQ-009 The read strobe SHALL be: fifo_rd_en = !fifo_empty & !clr & !rst & (occ + inflight - (m_valid & m_ready) < 2).
- inflight is 0 when REGOUT=0.
REQ-010 The invariant occ + inflight <= 2 SHALL hold in every cycle, so no captured word is ever dropped.
REQ-011 m_valid SHALL equal (occ != 0), and m_data SHALL equal the oldest buffered word.
REQ-012 Words SHALL leave on m_data in exactly the order they were read from the FIFO, with no duplication or loss.
REQ-013 A transfer SHALL occur on a rising edge of clk with m_valid=1 and m_ready=1.
- The head SHALL then advance and occ SHALL decrement, unless a capture happens in the same cycle.
REQ-014 A simultaneous capture and transfer SHALL leave occ unchanged and SHALL preserve ordering.
- This includes the case occ=1: the new word becomes the head in the next cycle.
REQ-015 Once m_valid=1, m_valid SHALL stay 1 and m_data SHALL stay stable until a transfer occurs.
REQ-016 Latency, measured from fifo_rd_en=1 in cycle t to m_valid=1 with the read word as head:
- REGOUT=1: cycle t+2.
- REGOUT=0: cycle t+1.
REQ-017 With m_ready held at 1 and the FIFO non-empty, throughput SHALL be one word per cycle after the initial latency.
REQ-018 With m_ready=0, the block SHALL issue at most 2 reads minus the words already buffered or in flight, then hold fifo_rd_en=0.
REQ-019 The block SHALL not act on fifo_rd_data in any cycle that is not a capture cycle.
REQ-020 fifo_clr SHALL equal clr combinationally.
REQ-021 clr=1 SHALL have these effects:
- at the next edge, occ and inflight are set to 0 and buffer contents are zeroed;
- in-flight data is discarded;
- m_valid=0 in the following cycle;
- fifo_rd_en=0 in the clr cycle itself.
REQ-022 clr SHALL take priority over a simultaneous capture or transfer; any transfer in the clr cycle still counts as accepted downstream.
REQ-023 When occ=0, m_data SHALL hold its last value; it is only meaningful while m_valid=1.

Reset
REQ-024 While rst=1, the following SHALL hold asynchronously: occ=0, inflight=0, buffer entries 0, m_valid=0, m_data=0, fifo_rd_en=0.
REQ-025 Assertion of rst mid-operation SHALL discard buffered and in-flight words without producing any output transfer.
REQ-026 After rst deasserts, the first fifo_rd_en SHALL occur no earlier than the first clk edge at which fifo_empty=0.

Verification
REQ-027 Streaming: REGOUT=1, FIFO preloaded with 0x01..0x10, m_ready=1 -> m_valid rises 2 cycles after the first fifo_rd_en, then 16 consecutive transfers 0x01..0x10 in order.
REQ-028 Backpressure: m_ready=0 with FIFO holding 0xA0..0xA5 -> exactly 2 fifo_rd_en pulses, m_data=0xA0 held stable; m_ready=1 -> 0xA0..0xA5 in order, with no gaps after the first transfer.
REQ-029 Toggling ready: m_ready alternating 1/0 per cycle over 32 words -> 32 transfers in order, occ never exceeds 2, no word lost or duplicated.
REQ-030 Flush: clr pulsed with occ=2 and a word in flight -> fifo_clr=1 in the same cycle, fifo_rd_en=0, m_valid=0 next cycle; the next pushed word 0x55 is the next output.
REQ-031 Reset mid-stream: rst asserted while m_valid=1, m_data=0x33 -> m_valid=0, m_data=0x00, fifo_rd_en=0 immediately, without waiting for a clock edge.
REQ-032 REGOUT=0: single word 0x7E, FIFO empty afterwards, m_ready=1 -> m_valid=1 with m_data=0x7E in cycle t+1, then m_valid=0.

Source files
------------

// File: rtl/fifo_stream_adapter_if.sv
// Stream side of the FIFO-to-stream adapter: valid/ready handshake.
// master drives m_valid/m_data, slave drives m_ready.
interface fifo_stream_adapter_if #(
   parameter int WIDTH = 8
);
   logic             m_valid;
   logic             m_ready;
   logic [WIDTH-1:0] m_data;

   modport master (
      output m_valid,
      output m_data,
      input  m_ready
   );

   modport slave (
      input  m_valid,
      input  m_data,
      output m_ready
   );
endinterface

// File: rtl/fifo_stream_adapter.sv
// Turns a FIFO rd_en/empty read port into a valid/ready stream via a
// 2-entry skid buffer.
// Ports: clk, rst (async, high), clr (sync flush);
//   FIFO side fifo_rd_en, fifo_rd_data, fifo_empty, fifo_clr;
//   stream side m (m_valid, m_ready, m_data).
module fifo_stream_adapter #(
   parameter int WIDTH  = 8,
   parameter int REGOUT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   output logic             fifo_rd_en,
   input  logic [WIDTH-1:0] fifo_rd_data,
   input  logic             fifo_empty,
   output logic             fifo_clr,
   fifo_stream_adapter_if.master m
);

   localparam logic REG_RD = (REGOUT != 0);

   logic [1:0]       occ;
   logic             inflight;
   logic [WIDTH-1:0] buf0;
   logic [WIDTH-1:0] buf1;

   logic       xfer;
   logic       cap;
   logic       room;
   logic [2:0] pend;

   assign xfer = m.m_valid & m.m_ready;

   // Words already owned: buffered plus the one the FIFO is returning.
   assign pend = {1'b0, occ} + {2'b00, inflight};

   // Room exists if, after this cycle's transfer, fewer than two remain.
   assign room = pend < (3'd2 + {2'b00, xfer});

   assign fifo_rd_en = !fifo_empty & !clr & !rst & room;
   assign fifo_clr   = clr;

   // Registered FIFO returns data one cycle after the strobe.
   assign cap = REG_RD ? inflight : fifo_rd_en;

   assign m.m_valid = (occ != 2'd0);
   assign m.m_data  = buf0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ      <= 2'd0;
         inflight <= 1'b0;
         buf0     <= '0;
         buf1     <= '0;
      end else if (clr) begin
         occ      <= 2'd0;
         inflight <= 1'b0;
         buf0     <= '0;
         buf1     <= '0;
      end else begin
         inflight <= REG_RD & fifo_rd_en;
         unique case (1'b1)
            cap && !xfer: begin
               if (occ == 2'd0)
                  buf0 <= fifo_rd_data;
               else
                  buf1 <= fifo_rd_data;
               occ <= occ + 2'd1;
            end
            !cap && xfer: begin
               // Head only moves when a second word exists, so m_data
               // keeps its last value once the buffer drains.
               if (occ == 2'd2)
                  buf0 <= buf1;
               occ <= occ - 2'd1;
            end
            cap && xfer: begin
               if (occ == 2'd2) begin
                  buf0 <= buf1;
                  buf1 <= fifo_rd_data;
               end else begin
                  buf0 <= fifo_rd_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_stream_adapter.sv
// Directed bench for fifo_stream_adapter, REGOUT=1 and REGOUT=0.
// Behavioural FIFOs feed each instance; a monitor logs transfers.
module tb_fifo_stream_adapter;

   localparam int W = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic clr_a;
   logic clr_b;
   assign clr_b = 1'b0;

   int checks   = 0;
   int failures = 0;

   fifo_stream_adapter_if #(.WIDTH(W)) sa ();
   fifo_stream_adapter_if #(.WIDTH(W)) sb ();

   logic         rd_en_a, empty_a, fclr_a;
   logic [W-1:0] rdata_a;
   logic         rd_en_b, empty_b, fclr_b;
   logic [W-1:0] rdata_b;

   fifo_stream_adapter #(.WIDTH(W), .REGOUT(1)) dut_a (
      .clk          (clk),
      .rst          (rst),
      .clr          (clr_a),
      .fifo_rd_en   (rd_en_a),
      .fifo_rd_data (rdata_a),
      .fifo_empty   (empty_a),
      .fifo_clr     (fclr_a),
      .m            (sa)
   );

   fifo_stream_adapter #(.WIDTH(W), .REGOUT(0)) dut_b (
      .clk          (clk),
      .rst          (rst),
      .clr          (clr_b),
      .fifo_rd_en   (rd_en_b),
      .fifo_rd_data (rdata_b),
      .fifo_empty   (empty_b),
      .fifo_clr     (fclr_b),
      .m            (sb)
   );

   // FIFO A: registered read
   logic [W-1:0] mem_a [64];
   int           wp_a = 0;
   int           rp_a = 0;
   assign empty_a = (wp_a == rp_a);
   always @(posedge clk) begin
      if (fclr_a) begin
         rp_a <= wp_a;
      end else if (rd_en_a) begin
         rdata_a <= mem_a[rp_a[5:0]];
         rp_a    <= rp_a + 1;
      end
   end

   // FIFO B: combinational read
   logic [W-1:0] mem_b [64];
   int           wp_b = 0;
   int           rp_b = 0;
   assign empty_b = (wp_b == rp_b);
   assign rdata_b = mem_b[rp_b[5:0]];
   always @(posedge clk) begin
      if (fclr_b)
         rp_b <= wp_b;
      else if (rd_en_b)
         rp_b <= rp_b + 1;
   end

   // Transfer monitor
   int           cyc    = 0;
   int           out_n  = 0;
   int           rd_cnt = 0;
   logic [W-1:0] out_d [256];
   int           out_c [256];
   int           out_nb = 0;
   logic [W-1:0] last_b = '0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (sa.m_valid && sa.m_ready) begin
         out_d[out_n[7:0]] <= sa.m_data;
         out_c[out_n[7:0]] <= cyc;
         out_n <= out_n + 1;
      end
      if (rd_en_a)
         rd_cnt <= rd_cnt + 1;
      if (sb.m_valid && sb.m_ready) begin
         last_b <= sb.m_data;
         out_nb <= out_nb + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic push_a(input logic [W-1:0] v);
      mem_a[wp_a[5:0]] = v;
      wp_a++;
   endtask

   task automatic push_b(input logic [W-1:0] v);
      mem_b[wp_b[5:0]] = v;
      wp_b++;
   endtask

   task automatic wait_out(input int target, input int bound,
                           input string tag);
      for (int i = 0; i < bound; i++) begin
         if (out_n >= target)
            break;
         tick();
      end
      chk(tag, out_n, target);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int rbase;

      rst        = 1'b0;
      clr_a      = 1'b0;
      sa.m_ready = 1'b0;
      sb.m_ready = 1'b1;
      #1 rst = 1'b1;
      #2;
      chk("rst_valid", sa.m_valid, 0);
      chk("rst_data", sa.m_data, 0);
      chk("rst_rden", rd_en_a, 0);
      chk("rst_rden_b", rd_en_b, 0);
      @(negedge clk);
      @(negedge clk);

      // Streaming 0x01..0x10
      rst        = 1'b0;
      sa.m_ready = 1'b1;
      base       = out_n;
      for (int i = 1; i <= 16; i++)
         push_a(W'(i));
      #1;
      chk("str_rden_t", rd_en_a, 1);
      tick();
      chk("str_valid_t1", sa.m_valid, 0);
      tick();
      chk("str_valid_t2", sa.m_valid, 1);
      chk("str_data_t2", sa.m_data, 8'h01);
      wait_out(base + 16, 40, "str_count");
      for (int i = 0; i < 16; i++)
         chk($sformatf("str_word%0d", i), out_d[base + i], i + 1);
      chk("str_span", out_c[base + 15] - out_c[base], 15);

      // Backpressure 0xA0..0xA5
      sa.m_ready = 1'b0;
      base       = out_n;
      rbase      = rd_cnt;
      for (int i = 0; i < 6; i++)
         push_a(W'(8'hA0 + i));
      repeat (5) tick();
      chk("bp_data_mid", sa.m_data, 8'hA0);
      repeat (5) tick();
      chk("bp_reads", rd_cnt - rbase, 2);
      chk("bp_valid", sa.m_valid, 1);
      chk("bp_data", sa.m_data, 8'hA0);
      sa.m_ready = 1'b1;
      wait_out(base + 6, 30, "bp_count");
      for (int i = 0; i < 6; i++)
         chk($sformatf("bp_word%0d", i), out_d[base + i], 8'hA0 + i);
      chk("bp_span", out_c[base + 5] - out_c[base], 5);

      // Toggling ready over 32 words
      sa.m_ready = 1'b0;
      base       = out_n;
      for (int i = 0; i < 32; i++)
         push_a(W'(8'h40 + i));
      for (int i = 0; i < 400 && out_n < base + 32; i++) begin
         sa.m_ready = ~sa.m_ready;
         tick();
      end
      sa.m_ready = 1'b0;
      chk("tog_count", out_n - base, 32);
      for (int i = 0; i < 32; i++)
         chk($sformatf("tog_word%0d", i), out_d[base + i], 8'h40 + i);
      tick();
      chk("tog_no_extra", out_n - base, 32);

      // Flush with two words buffered
      for (int i = 0; i < 4; i++)
         push_a(W'(8'h90 + i));
      repeat (4) tick();
      chk("fl1_pre_valid", sa.m_valid, 1);
      clr_a = 1'b1;
      #1;
      chk("fl1_fifo_clr", fclr_a, 1);
      chk("fl1_rden", rd_en_a, 0);
      tick();
      clr_a = 1'b0;
      chk("fl1_valid", sa.m_valid, 0);
      chk("fl1_data", sa.m_data, 0);

      // Flush with a word in flight and more waiting in the FIFO
      push_a(8'h66);
      push_a(8'h67);
      #1;
      chk("fl2_pre_rden", rd_en_a, 1);
      tick();
      clr_a = 1'b1;
      #1;
      chk("fl2_rden", rd_en_a, 0);
      chk("fl2_fifo_clr", fclr_a, 1);
      tick();
      clr_a = 1'b0;
      chk("fl2_valid", sa.m_valid, 0);
      tick();
      chk("fl2_valid_late", sa.m_valid, 0);
      base = out_n;
      push_a(8'h55);
      sa.m_ready = 1'b1;
      wait_out(base + 1, 10, "fl_next_count");
      chk("fl_next_word", out_d[base], 8'h55);
      sa.m_ready = 1'b0;

      // Reset mid-stream
      push_a(8'h33);
      for (int i = 0; i < 10 && !sa.m_valid; i++)
         tick();
      chk("mr_pre_valid", sa.m_valid, 1);
      chk("mr_pre_data", sa.m_data, 8'h33);
      base = out_n;
      push_a(8'h34);
      #1;
      chk("mr_pre_rden", rd_en_a, 1);
      #2 rst = 1'b1;
      #1;
      chk("mr_valid", sa.m_valid, 0);
      chk("mr_data", sa.m_data, 0);
      chk("mr_rden", rd_en_a, 0);
      @(negedge clk);
      rst   = 1'b0;
      clr_a = 1'b1;
      tick();
      clr_a = 1'b0;
      tick();
      chk("mr_no_xfer", out_n, base);
      chk("mr_idle_valid", sa.m_valid, 0);

      // REGOUT=0 single word
      push_b(8'h7E);
      #1;
      chk("r0_rden_t", rd_en_b, 1);
      tick();
      chk("r0_valid_t1", sb.m_valid, 1);
      chk("r0_data_t1", sb.m_data, 8'h7E);
      tick();
      chk("r0_valid_t2", sb.m_valid, 0);
      chk("r0_data_hold", sb.m_data, 8'h7E);
      chk("r0_count", out_nb, 1);
      chk("r0_word", last_b, 8'h7E);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
